// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : fetch request valid (fetch -> memory)
//   imem_addr  : byte address of the fetch (fetch -> memory)
//   imem_ready : imem_rdata is valid for the current imem_addr (memory -> fetch)
//   imem_rdata : instruction word (memory -> fetch)
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// holds the IF/ID pipeline register. Takes redirects resolved in ID (one bubble,
// no delay slot), absorbs ID stalls and variable-latency memory responses.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   id_stall        : ID cannot accept a new instruction
//   id_pcsrc        : 00 seq, 01 beq/bne, 10 j/jal, 11 jr/jalr for id_inst
//   id_branch_taken : branch compare result (pcsrc 01 only)
//   id_rs_value     : forwarded rs, jr/jalr target
//   id_inst/id_pc/id_pc_plus4/id_valid : registered IF/ID outputs
//
// state | meaning
// FETCH | request at pc outstanding; response goes straight to IF/ID
// HOLD  | word for pc fetched but ID stalled; parked in buf_inst, no request
// DROP  | redirect taken while a request was unanswered; wait it out, discard
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic         id_stall,
  input  logic [1:0]   id_pcsrc,
  input  logic         id_branch_taken,
  input  logic [31:0]  id_rs_value,
  output logic [31:0]  id_inst,
  output logic [31:0]  id_pc,
  output logic [31:0]  id_pc_plus4,
  output logic         id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;

  logic        accept;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] branch_off;
  logic [31:0] pc_inc;

  assign accept     = ~id_valid_q | ~id_stall;
  assign redirect   = id_valid_q & ~id_stall &
                      (id_pcsrc[1] | ((id_pcsrc == 2'b01) & id_branch_taken));
  assign branch_off = {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};
  assign pc_inc     = pc_q + 32'd4;

  always_comb begin
    target = id_pc_plus4_q;
    case (id_pcsrc)
      2'b01:   target = id_pc_plus4_q + branch_off;
      2'b10:   target = {id_pc_plus4_q[31:28], id_inst_q[25:0], 2'b00};
      2'b11:   target = id_rs_value;
      default: target = id_pc_plus4_q;
    endcase
  end

  // Request is a function of state only; reset forces it low immediately.
  assign imem.imem_req  = ~rst & (state_q != HOLD);
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_inst_d    = buf_inst_q;
    pend_target_d = pend_target_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;

    case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          if (redirect) begin
            // Word returned this cycle is wrong-path.
            pc_d       = target;
            id_valid_d = 1'b0;
          end else if (accept) begin
            id_inst_d     = imem.imem_rdata;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_inc;
            id_valid_d    = 1'b1;
            pc_d          = pc_inc;
          end else begin
            buf_inst_d = imem.imem_rdata;
            state_d    = HOLD;
          end
        end else begin
          if (redirect) begin
            // Address must stay stable until memory answers, so park the target.
            pend_target_d = target;
            id_valid_d    = 1'b0;
            state_d       = DROP;
          end else if (accept) begin
            id_valid_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d       = target;
          id_valid_d = 1'b0;
          state_d    = FETCH;
        end else if (accept) begin
          id_inst_d     = buf_inst_q;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_inc;
          id_valid_d    = 1'b1;
          pc_d          = pc_inc;
          state_d       = FETCH;
        end
      end

      DROP: begin
        if (imem.imem_ready) begin
          pc_d    = pend_target_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      buf_inst_q    <= 32'd0;
      pend_target_q <= 32'd0;
      id_inst_q     <= 32'd0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd4;
      id_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_inst_q    <= buf_inst_d;
      pend_target_q <= pend_target_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a small program table models instruction memory and
// the decoder's pcsrc; expected IF/ID handoffs are queued by the stimulus and
// popped by a negedge monitor whenever ID consumes an instruction.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        id_stall;
  logic [1:0]  id_pcsrc;
  logic        id_branch_taken;
  logic [31:0] id_rs_value;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        mem_ready;

  fetch_unit_if ifc ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (ifc.master),
    .id_stall        (id_stall),
    .id_pcsrc        (id_pcsrc),
    .id_branch_taken (id_branch_taken),
    .id_rs_value     (id_rs_value),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_valid        (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program table: overrides for specific addresses; other words are pc-tagged NOPs.
  logic [31:0] prog_addr [8];
  logic [31:0] prog_inst [8];
  logic [1:0]  prog_src  [8];
  int          prog_n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {16'h2400, a[15:0]};
    for (int i = 0; i < 8; i++)
      if (i < prog_n && prog_addr[i] == a) w = prog_inst[i];
    return w;
  endfunction

  function automatic logic [1:0] src_of(input logic [31:0] a);
    logic [1:0] s;
    s = 2'b00;
    for (int i = 0; i < 8; i++)
      if (i < prog_n && prog_addr[i] == a) s = prog_src[i];
    return s;
  endfunction

  assign ifc.imem_ready = mem_ready;
  assign ifc.imem_rdata = mem_word(ifc.imem_addr);
  assign id_pcsrc       = id_valid ? src_of(id_pc) : 2'b00;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  logic mon_en;
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && id_valid && !id_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst actual_pc=%h required=none", id_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_id_pc", id_pc, e.pc);
        check("sb_id_inst", id_inst, e.inst);
        check("sb_id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_prog(input logic [31:0] a, input logic [31:0] w, input logic [1:0] s);
    prog_addr[prog_n] = a;
    prog_inst[prog_n] = w;
    prog_src[prog_n]  = s;
    prog_n++;
  endtask

  task automatic expect_pc(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.inst = mem_word(a);
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; the first reset edge sees whatever state the DUT is in.
  task automatic reset_dut();
    mon_en          = 1'b0;
    id_stall        = 1'b0;
    mem_ready       = 1'b1;
    id_branch_taken = 1'b0;
    id_rs_value     = 32'd0;
    rst             = 1'b1;
    #1;
    check("rst_req_low_now", {31'd0, ifc.imem_req}, 32'd0);
    repeat (3) step();
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_pc_plus4", id_pc_plus4, 32'd4);
    check("rst_req", {31'd0, ifc.imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    check("first_req", {31'd0, ifc.imem_req}, 32'd1);
    check("first_addr", ifc.imem_addr, 32'h0);
  endtask

  task automatic start_scn();
    mon_en = 1'b1;
  endtask

  task automatic finish_scn(input string name);
    step();
    mon_en = 1'b0;
    check({name, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prog_n    = 0;
    mon_en    = 1'b0;
    rst       = 1'b1;
    id_stall  = 1'b0;
    mem_ready = 1'b1;
    id_branch_taken = 1'b0;
    id_rs_value     = 32'd0;
    step();

    // Sequential fetch after reset
    prog_n = 0;
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    start_scn();
    step(); check("seq_addr_e1", ifc.imem_addr, 32'h4);
    repeat (3) step();
    finish_scn("seq");

    // beq taken, imm16 = 3 -> 0x18
    prog_n = 0;
    add_prog(32'h8, 32'h1022_0003, 2'b01);
    reset_dut();
    id_branch_taken = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    expect_pc(32'h18); expect_pc(32'h1C);
    start_scn();
    repeat (4) step();
    check("beq_bubble", {31'd0, id_valid}, 32'd0);
    check("beq_target", ifc.imem_addr, 32'h18);
    repeat (2) step();
    finish_scn("beq_fwd");

    // beq taken, imm16 = 0xFFFF -> back to 0x8
    prog_n = 0;
    add_prog(32'h8, 32'h1022_FFFF, 2'b01);
    reset_dut();
    id_branch_taken = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'h8);
    start_scn();
    repeat (4) step();
    check("beq_back_target", ifc.imem_addr, 32'h8);
    check("beq_back_bubble", {31'd0, id_valid}, 32'd0);
    repeat (2) step();
    finish_scn("beq_back");

    // beq not taken
    prog_n = 0;
    add_prog(32'h8, 32'h1022_0003, 2'b01);
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    expect_pc(32'hC); expect_pc(32'h10);
    start_scn();
    repeat (4) step();
    check("beq_nt_valid", {31'd0, id_valid}, 32'd1);
    step();
    finish_scn("beq_nt");

    // j 0x1000, j 0x100, jr 0x200
    prog_n = 0;
    add_prog(32'h0,    32'h0800_0400, 2'b10);
    add_prog(32'h1000, 32'h0800_0040, 2'b10);
    add_prog(32'h100,  32'h00A0_0008, 2'b11);
    reset_dut();
    id_rs_value = 32'h200;
    expect_pc(32'h0); expect_pc(32'h1000); expect_pc(32'h100);
    expect_pc(32'h200); expect_pc(32'h204);
    start_scn();
    repeat (2) step();
    check("j_target_1000", ifc.imem_addr, 32'h1000);
    step();
    check("j_pc_plus4", id_pc_plus4, 32'h1004);
    step();
    check("j_target_100", ifc.imem_addr, 32'h100);
    check("j_bubble", {31'd0, id_valid}, 32'd0);
    repeat (2) step();
    check("jr_target_200", ifc.imem_addr, 32'h200);
    repeat (2) step();
    finish_scn("jumps");

    // Stall while fetch of 0x10 completes -> HOLD
    prog_n = 0;
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    expect_pc(32'h10); expect_pc(32'h14);
    start_scn();
    repeat (4) step();
    id_stall = 1'b1;
    step();
    check("hold_req", {31'd0, ifc.imem_req}, 32'd0);
    check("hold_inst", id_inst, 32'h2400_000C);
    step();
    check("hold_req2", {31'd0, ifc.imem_req}, 32'd0);
    step();
    check("hold_inst3", id_inst, 32'h2400_000C);
    id_stall = 1'b0;
    step();
    check("hold_release_inst", id_inst, 32'h2400_0010);
    check("hold_release_addr", ifc.imem_addr, 32'h14);
    step();
    finish_scn("hold");

    // Jump to 0x40 while memory is not ready -> DROP
    prog_n = 0;
    add_prog(32'h8, 32'h0800_0010, 2'b10);
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    expect_pc(32'h40); expect_pc(32'h44);
    start_scn();
    repeat (3) step();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drop_addr_held", ifc.imem_addr, 32'hC);
      check("drop_valid", {31'd0, id_valid}, 32'd0);
    end
    mem_ready = 1'b1;
    step();
    check("drop_next_addr", ifc.imem_addr, 32'h40);
    check("drop_valid_end", {31'd0, id_valid}, 32'd0);
    repeat (2) step();
    finish_scn("drop");

    // Memory wait-state without redirect -> single bubble
    prog_n = 0;
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    start_scn();
    step();
    mem_ready = 1'b0;
    step();
    check("wait_bubble", {31'd0, id_valid}, 32'd0);
    check("wait_addr", ifc.imem_addr, 32'h4);
    mem_ready = 1'b1;
    repeat (2) step();
    finish_scn("wait");

    // jr to 0xFFFFFFFC then increment wraps to 0
    prog_n = 0;
    add_prog(32'h0, 32'h00A0_0008, 2'b11);
    reset_dut();
    id_rs_value = 32'hFFFF_FFFC;
    expect_pc(32'h0); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
    start_scn();
    repeat (3) step();
    check("wrap_addr", ifc.imem_addr, 32'h0);
    check("wrap_pc_plus4", id_pc_plus4, 32'h0);
    step();
    finish_scn("wrap");

    // Reset while in DROP (first reset edge sees DROP with ready high)
    prog_n = 0;
    add_prog(32'h8, 32'h0800_0010, 2'b10);
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    start_scn();
    repeat (3) step();
    mem_ready = 1'b0;
    repeat (2) step();
    finish_scn("pre_drop_rst");
    prog_n = 0;
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4);
    start_scn();
    repeat (2) step();
    finish_scn("post_drop_rst");

    // Reset while in HOLD
    prog_n = 0;
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    start_scn();
    repeat (4) step();
    id_stall = 1'b1;
    repeat (2) step();
    check("pre_hold_rst_req", {31'd0, ifc.imem_req}, 32'd0);
    finish_scn("pre_hold_rst");
    reset_dut();
    expect_pc(32'h0); expect_pc(32'h4);
    start_scn();
    repeat (2) step();
    finish_scn("post_hold_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core. Holds the PC, issues requests to instruction memory, and owns the IF/ID pipeline register whose `id_inst` drives the instruction decoder. It takes redirects resolved in ID and squashes wrong-path fetches. It also absorbs ID stalls and variable-latency memory responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: byte address of the fetch; held stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready` in 1: `imem_rdata` valid for the current `imem_addr`. May be tied 1 for combinational ROM.
- `imem_rdata` in 32: instruction word.
- `id_stall` in 1: ID cannot accept a new instruction. Only meaningful when `id_valid`=1.
- `id_pcsrc` in 2: decoder PC-source code for `id_inst`: 00 sequential, 01 beq/bne, 10 j/jal, 11 jr/jalr.
- `id_branch_taken` in 1: branch compare result for `id_inst`, used only when `id_pcsrc`=01.
- `id_rs_value` in 32: forwarded rs value, used as the jr/jalr target.
- `id_inst` out 32: IF/ID instruction.
- `id_pc` out 32: address of `id_inst`.
- `id_pc_plus4` out 32: `id_pc`+4, used for jal/jalr link.
- `id_valid` out 1: `id_inst` holds a live instruction.

## Operation
- ID accepts when `accept = ~id_valid | ~id_stall`.
- `redirect = id_valid & ~id_stall & (pcsrc==10 | pcsrc==11 | (pcsrc==01 & id_branch_taken))`.
- Redirect target. All arithmetic is mod 2^32 with no overflow detection.
  - 01: `id_pc + 4 + (sext(id_inst[15:0]) << 2)`.
  - 10: `{id_pc_plus4[31:28], id_inst[25:0], 2'b00}`.
  - 11: `id_rs_value`. No alignment check.
- No branch delay slot. The instruction fetched in the redirect cycle is discarded.
- FSM states: FETCH, HOLD, DROP. Registers: `pc`, `buf_inst`, `pend_target`.
- **FETCH**: `imem_req`=1, `imem_addr`=`pc`.
  - `imem_ready` & `redirect`: discard rdata, `pc`<=target, `id_valid`<=0. Stay in FETCH.
  - `imem_ready` & `accept`: `id_inst`<=rdata, `id_pc`<=`pc`, `id_valid`<=1, `pc`<=`pc`+4.
  - `imem_ready` & ~`accept`: `buf_inst`<=rdata, go to HOLD. `pc` unchanged.
  - ~`imem_ready` & `redirect`: `pend_target`<=target, `id_valid`<=0, go to DROP.
  - ~`imem_ready` & `accept`: `id_valid`<=0 (bubble).
  - ~`imem_ready` & ~`accept`: hold.
- **HOLD**: `imem_req`=0.
  - ~`accept`: hold.
  - `redirect`: discard `buf_inst`, `pc`<=target, `id_valid`<=0, go to FETCH.
  - otherwise: `id_inst`<=`buf_inst`, `id_pc`<=`pc`, `id_valid`<=1, `pc`<=`pc`+4, go to FETCH.
- **DROP**: `imem_req`=1, `imem_addr`=old `pc`. Here `id_valid`=0, so no redirect can occur.
  - On `imem_ready`: discard rdata, `pc`<=`pend_target`, go to FETCH.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; state FETCH.
  - `id_valid`=0, `id_inst`=0, `id_pc`=0, `id_pc_plus4`=4.
  - `buf_inst`=0, `pend_target`=0.
  - `imem_req`=0 while `rst` is high.
- First request after reset: `RESET_PC`, in the cycle after `rst` falls.
- Latency: the word returned with `imem_ready` at cycle N is on `id_inst` at cycle N+1.
- Throughput with `imem_ready`≡1: one instruction per cycle.
- Taken branch / jump / jr costs exactly one bubble cycle (`id_valid`=0).
- `id_*` outputs are registered. `imem_req` and `imem_addr` are decoded from state and `pc` only, with no combinational path from `imem_ready`.
- Reset mid-operation:
  - Synchronous; overrides every state including DROP and HOLD.
  - Pending targets and buffered words are lost.
  - An in-flight memory response is ignored.
- Wrap-around: `pc`=32'hFFFF_FFFC increments to 0.

## Test plan
- **Reset:** `rst` high 3 cycles, then low, `imem_ready`=1, rdata=`pc`-tagged NOPs.
  - Cycle 1 after release: `imem_addr`=0x0.
  - Following cycles: `id_pc` sequence 0x0, 0x4, 0x8 with `id_valid`=1.
  - Every output at its reset value while `rst` is high.
- **beq taken:** beq at 0x8 with imm16=0x0003, `id_branch_taken`=1.
  - Next `imem_addr`=0x18; one bubble; the word fetched from 0xC never appears.
  - Repeat with imm16=0xFFFF: target 0x8.
  - Not taken: 0xC proceeds normally.
- **Jumps:** j at 0x1000 with jimm=0x0000040 → `imem_addr`=0x100. jr with `id_rs_value`=0x200 → 0x200. `id_pc_plus4`=0x1004 while j is in ID.
- **Stall/HOLD:** `id_stall`=1 for 3 cycles with `id_valid`=1 while fetch of 0x10 completes.
  - State HOLD, `imem_req`=0, `id_inst` unchanged.
  - On release: `id_inst`=word@0x10, then 0x14 requested.
  - No instruction is lost or duplicated.
- **DROP:** `imem_ready`=0 for 4 cycles while a jump to 0x40 is in ID.
  - `imem_addr` stays at the old address until ready.
  - That response is discarded; next request is 0x40.
  - `id_valid`=0 throughout.
- **Reset mid-operation:** assert `rst` while in DROP and in HOLD → next request `RESET_PC`, `id_valid`=0.
